// File: rtl/icu_sequencer_if.sv
// Handshake bundle between the MC14500B ICU/reset module and the program sequencer.
// The master side drives the ICU flags and operand; the slave (sequencer) drives fetch control.
interface icu_sequencer_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) ();
    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    logic                pc_reset;
    logic                jmp;
    logic                rtn;
    logic                flag_f;
    logic                flag_o;
    logic                resume;
    logic [ADDR_W-1:0]   jump_target;

    logic [ADDR_W-1:0]   pc;
    logic                fetch_en;
    logic                halted;
    logic                fault;
    logic [1:0]          fault_code;
    logic [DEPTH_W-1:0]  depth;
    logic                scan_done;

    modport master (
        output pc_reset, jmp, rtn, flag_f, flag_o, resume, jump_target,
        input  pc, fetch_en, halted, fault, fault_code, depth, scan_done
    );

    modport slave (
        input  pc_reset, jmp, rtn, flag_f, flag_o, resume, jump_target,
        output pc, fetch_en, halted, fault, fault_code, depth, scan_done
    );
endinterface

// File: rtl/icu_sequencer.sv
// Program sequencer for the MC14500B ICU: owns the PC and return stack, and turns
// JMP/RTN/FLGF into calls, returns and halt while gating fetch around power-up reset.
module icu_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    icu_sequencer_if.slave bus
);
    localparam int IDX_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_e;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_OVER  = 2'b01;
    localparam logic [1:0] CODE_UNDER = 2'b10;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [1:0]         code_q, code_d;
    logic               armed_q, armed_d;
    logic               scan_q, scan_d;
    logic               push;

    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  pc_inc;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   top_idx;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign wr_idx  = depth_q[IDX_W-1:0];
    // Wraps correctly when the stack is full: low bits are zero, minus one is the last slot.
    assign top_idx = depth_q[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        code_d  = code_q;
        armed_d = armed_q;
        scan_d  = 1'b0;
        push    = 1'b0;

        if (bus.pc_reset) begin
            pc_d    = '0;
            depth_d = '0;
            code_d  = CODE_NONE;
            armed_d = 1'b1;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (armed_q) state_d = S_RUN;
                end
                S_RUN: begin
                    scan_d = bus.flag_o;
                    // Return beats call, and both beat halt.
                    if (bus.rtn) begin
                        if (depth_q == '0) begin
                            state_d = S_FAULT;
                            code_d  = CODE_UNDER;
                        end else begin
                            pc_d    = stack_q[top_idx];
                            depth_d = depth_q - DEPTH_W'(1);
                        end
                    end else if (bus.jmp) begin
                        if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
                            state_d = S_FAULT;
                            code_d  = CODE_OVER;
                        end else begin
                            push    = 1'b1;
                            pc_d    = bus.jump_target;
                            depth_d = depth_q + DEPTH_W'(1);
                        end
                    end else if (bus.flag_f) begin
                        pc_d    = pc_inc;
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                S_HALT: begin
                    if (bus.resume) state_d = S_RUN;
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            depth_q <= '0;
            code_q  <= CODE_NONE;
            armed_q <= 1'b0;
            scan_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            code_q  <= code_d;
            armed_q <= armed_d;
            scan_q  <= scan_d;
        end
    end

    // Stack contents need no reset: depth alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) stack_q[wr_idx] <= pc_inc;
    end

    assign bus.pc         = pc_q;
    assign bus.fetch_en   = (state_q == S_RUN);
    assign bus.halted     = (state_q == S_HALT);
    assign bus.fault      = (state_q == S_FAULT);
    assign bus.fault_code = code_q;
    assign bus.depth      = depth_q;
    assign bus.scan_done  = scan_q;
endmodule

// File: tb/tb_icu_sequencer.sv
// Randomised and directed bench for icu_sequencer, checked every cycle against a
// queue-based behavioural model of the sequencer rules.
module tb_icu_sequencer;
    localparam int AW = 8;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    icu_sequencer_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) bus ();

    icu_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    int m_mode  = M_IDLE;
    int m_pc    = 0;
    int m_code  = 0;
    int m_armed = 0;
    int m_scan  = 0;
    int m_stack[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        if (reset) begin
            m_mode = M_IDLE; m_pc = 0; m_code = 0; m_armed = 0; m_scan = 0;
            m_stack.delete();
        end else if (bus.pc_reset) begin
            m_mode = M_IDLE; m_pc = 0; m_code = 0; m_armed = 1; m_scan = 0;
            m_stack.delete();
        end else begin
            m_scan = (m_mode == M_RUN && bus.flag_o) ? 1 : 0;
            case (m_mode)
                M_IDLE: if (m_armed != 0) m_mode = M_RUN;
                M_RUN: begin
                    if (bus.rtn) begin
                        if (m_stack.size() == 0) begin
                            m_mode = M_FAULT; m_code = 2;
                        end else begin
                            m_pc = m_stack.pop_back();
                        end
                    end else if (bus.jmp) begin
                        if (m_stack.size() == SD) begin
                            m_mode = M_FAULT; m_code = 1;
                        end else begin
                            m_stack.push_back((m_pc + 1) % 256);
                            m_pc = int'(bus.jump_target);
                        end
                    end else if (bus.flag_f) begin
                        m_pc = (m_pc + 1) % 256;
                        m_mode = M_HALT;
                    end else begin
                        m_pc = (m_pc + 1) % 256;
                    end
                end
                M_HALT: if (bus.resume) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", int'(bus.pc), m_pc);
            check("fetch_en", int'(bus.fetch_en), (m_mode == M_RUN) ? 1 : 0);
            check("halted", int'(bus.halted), (m_mode == M_HALT) ? 1 : 0);
            check("fault", int'(bus.fault), (m_mode == M_FAULT) ? 1 : 0);
            check("fault_code", int'(bus.fault_code), m_code);
            check("depth", int'(bus.depth), m_stack.size());
            check("scan_done", int'(bus.scan_done), m_scan);
        end
    end

    task automatic step(input logic r, input logic pr, input logic j, input logic rt,
                        input logic ff, input logic fo, input logic rs, input logic [7:0] tgt);
        reset           = r;
        bus.pc_reset    = pr;
        bus.jmp         = j;
        bus.rtn         = rt;
        bus.flag_f      = ff;
        bus.flag_o      = fo;
        bus.resume      = rs;
        bus.jump_target = tgt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        check("rst_pc", int'(bus.pc), 0);
        check("rst_fetch", int'(bus.fetch_en), 0);
        check("rst_depth", int'(bus.depth), 0);

        // Power-up sequence
        step(0, 1, 0, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 0, 0, 8'h00);
        check("pr_fetch_low", int'(bus.fetch_en), 0);
        idle();
        check("pu_fetch", int'(bus.fetch_en), 1);
        check("pu_pc0", int'(bus.pc), 0);
        for (int i = 1; i <= 3; i++) begin
            idle();
            check("pu_pc_seq", int'(bus.pc), i);
        end

        // Call and return
        repeat (12) idle();
        step(0, 0, 0, 0, 0, 1, 0, 8'h00);
        check("pc_0x10", int'(bus.pc), 16);
        check("scan_pulse", int'(bus.scan_done), 1);
        step(0, 0, 1, 0, 0, 0, 0, 8'h40);
        check("call_pc", int'(bus.pc), 8'h40);
        check("call_depth", int'(bus.depth), 1);
        check("scan_one_cycle", int'(bus.scan_done), 0);
        idle(); idle();
        step(0, 0, 0, 1, 0, 0, 0, 8'h00);
        check("ret_pc", int'(bus.pc), 8'h11);
        check("ret_depth", int'(bus.depth), 0);

        // Overflow
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0, 8'(8'h20 + i));
        check("ovf_depth4", int'(bus.depth), 4);
        step(0, 0, 1, 0, 0, 0, 0, 8'h24);
        check("ovf_fault", int'(bus.fault), 1);
        check("ovf_code", int'(bus.fault_code), 1);
        check("ovf_pc", int'(bus.pc), 8'h23);
        check("ovf_fetch", int'(bus.fetch_en), 0);
        idle();
        check("ovf_hold", int'(bus.pc), 8'h23);
        step(0, 1, 0, 0, 0, 0, 0, 8'h00);
        check("ovf_rec_pc", int'(bus.pc), 0);
        check("ovf_rec_code", int'(bus.fault_code), 0);
        idle();
        check("ovf_rec_run", int'(bus.fetch_en), 1);

        // Underflow, then simultaneous jmp+rtn
        step(0, 0, 0, 1, 0, 0, 0, 8'h00);
        check("unf_code", int'(bus.fault_code), 2);
        check("unf_pc", int'(bus.pc), 0);
        step(0, 1, 0, 0, 0, 0, 0, 8'h00);
        idle();
        step(0, 0, 1, 0, 0, 0, 0, 8'h30);
        step(0, 0, 1, 1, 1, 0, 0, 8'h50);
        check("both_pc", int'(bus.pc), 1);
        check("both_depth", int'(bus.depth), 0);
        check("both_not_halt", int'(bus.halted), 0);

        // Halt at 0xFE and wrap
        step(0, 0, 1, 0, 0, 0, 0, 8'hFE);
        step(0, 0, 0, 0, 1, 0, 0, 8'h00);
        check("halt_pc", int'(bus.pc), 8'hFF);
        check("halt_flag", int'(bus.halted), 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, i[0], i[1], 1, 1, 0, 8'h12);
            check("halt_hold_pc", int'(bus.pc), 8'hFF);
            check("halt_hold_flag", int'(bus.halted), 1);
        end
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        check("resume_fetch", int'(bus.fetch_en), 1);
        idle();
        check("wrap_pc", int'(bus.pc), 0);

        // Reset mid-call
        step(0, 0, 1, 0, 0, 0, 0, 8'h80);
        check("mid_depth2", int'(bus.depth), 2);
        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        check("mid_rst_depth", int'(bus.depth), 0);
        check("mid_rst_pc", int'(bus.pc), 0);
        repeat (3) idle();
        check("mid_rst_no_run", int'(bus.fetch_en), 0);

        // Randomised traffic
        step(0, 1, 0, 0, 0, 0, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(199) == 0), ($urandom_range(39) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(6) == 0),
                 ($urandom_range(15) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(3) == 0), 8'($urandom));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icu_sequencer.md
# icu_sequencer

Program sequencer for the MC14500B ICU. It owns the program counter and a small return-address stack, and it turns the ICU's JMP, RTN and FLGF outputs into PC updates, subroutine calls/returns and halt. It also gates instruction fetch around the power-up reset sequence. It sits between the reset module (consumes `pc_reset`) and program memory (drives `pc`, `fetch_en`).

## Interface
- `ADDR_W`, 8, program-memory address width
- `STACK_DEPTH`, 4, return-stack entries (power of two, ≥2)
- `clk` in 1: single system clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high; clears all state
- `pc_reset` in 1: PC-hold request from reset module; level-sensitive
- `jmp` in 1: ICU JMP flag; call to `jump_target`
- `rtn` in 1: ICU RTN flag; return to top-of-stack
- `flag_f` in 1: ICU FLGF; halt request
- `flag_o` in 1: ICU FLG0; end-of-scan marker
- `resume` in 1: leave HALT
- `jump_target` in ADDR_W: operand field of current instruction
- `pc` out ADDR_W: current fetch address
- `fetch_en` out 1: program-memory read enable / ICU advance
- `halted` out 1: state is HALT
- `fault` out 1: state is FAULT
- `fault_code` out 2: 00 none, 01 overflow, 10 underflow
- `depth` out clog2(STACK_DEPTH)+1: stack occupancy
- `scan_done` out 1: one-cycle pulse per FLG0 in RUN

## Operation
- States: IDLE, RUN, HALT, FAULT. Reset → IDLE.
- Reset values: `pc`=0, `fetch_en`=0, `halted`=0, `fault`=0, `fault_code`=00, `depth`=0, `scan_done`=0, `armed`=0.
- `pc_reset`=1 in any state:
  - `pc`←0, `depth`←0, `fault_code`←00.
  - `armed`←1, next state IDLE.
  - Overrides every other input.
- IDLE: `fetch_en`=0. If `armed`=1 and `pc_reset`=0, go to RUN. An unarmed IDLE waits indefinitely.
- RUN: `fetch_en`=1. One action per cycle, in priority order:
  1. `rtn` with `depth`=0 → FAULT, code 10; `pc` holds.
  2. `rtn` → `pc`←stack[top]; `depth`−1.
  3. `jmp` with `depth`=STACK_DEPTH → FAULT, code 01; `pc` holds.
  4. `jmp` → push (`pc`+1) mod 2^ADDR_W; `pc`←`jump_target`; `depth`+1.
  5. `flag_f` → `pc`←`pc`+1; go to HALT.
  6. Otherwise `pc`←`pc`+1.
- `jmp` and `rtn` together: the return is taken and `jmp` is ignored.
- `flag_f` together with `jmp` or `rtn`: the jump/return is taken and `flag_f` is ignored.
- PC increment wraps silently from 2^ADDR_W−1 to 0.
- `scan_done`=1 the cycle after `flag_o`=1 is sampled in RUN, independent of the action taken.
- HALT: `fetch_en`=0, `halted`=1, `pc` and stack hold. `resume`=1 → RUN next cycle. `jmp`/`rtn`/`flag_f` are ignored.
- FAULT: `fetch_en`=0, `fault`=1; `pc`, stack and `fault_code` hold. Exits only via `reset`, or via `pc_reset` (→ IDLE).
- Stack is LIFO register file, indexed by `depth`; no read-before-write hazard, since push and pop never occur in the same cycle.

## Timing
- Inputs sampled on rising `clk`; all outputs registered and valid in the cycle after the sampling edge.
- JMP/RTN latency is 1 cycle: the target appears on `pc` in the cycle after the flag is sampled.
- IDLE→RUN: `fetch_en` rises on the cycle after the first edge where `pc_reset`=0 with `armed`=1, with `pc`=0.
- `reset` asserted mid-operation: all outputs at reset values from the next cycle; `armed`=0, so RUN needs a fresh `pc_reset` pulse.
- `pc_reset` asserted mid-RUN: `fetch_en`=0 and `pc`=0 the next cycle; RUN resumes one cycle after `pc_reset` falls.

## Test plan
- Power-up: reset 2 cycles, then `pc_reset` high 2 cycles then low → `fetch_en` rises one cycle after `pc_reset` falls; `pc` sequence 0,1,2,3.
- Call/return: RUN at `pc`=0x10, `jmp` with `jump_target`=0x40 → `pc`=0x40, `depth`=1; later `rtn` → `pc`=0x11, `depth`=0.
- Overflow: STACK_DEPTH=4, five nested `jmp` → fifth gives `fault`=1, `fault_code`=01, `pc` frozen, `fetch_en`=0; `pc_reset` pulse recovers to `pc`=0.
- Underflow and simultaneity: `rtn` at `depth`=0 → `fault_code`=10. Separately, `jmp`+`rtn` together at `depth`=1 → return taken, `depth`=0.
- Halt and wrap: at `pc`=0xFE assert `flag_f` → `pc`=0xFF, `halted`=1 and held 5 cycles; `resume` → next `pc`=0x00.
- Reset mid-call: `depth`=2, assert `reset` → `depth`=0, `pc`=0, IDLE; no RUN until a new `pc_reset` pulse.
